// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer, the PLL and the downstream reset consumers.
// lock_loss_cnt is present only when PLL_LOCK_LOSS_CNT_EN is defined.
interface pll_lock_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          sys_reset_n;
  logic          lock_ok;
  logic          fail;
  logic [2:0]    state;
  logic [RW-1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0]    lock_loss_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_reset_n, lock_ok, fail, state, retry_cnt, lock_loss_cnt
  );
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_reset_n, lock_ok, fail, state, retry_cnt, lock_loss_cnt
  );
`else
  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_reset_n, lock_ok, fail, state, retry_cnt
  );
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_reset_n, lock_ok, fail, state, retry_cnt
  );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// Brings the fabric PLL from power-up to a trusted lock and owns the downstream system reset.
// Runs on refclk; optional lock-loss counter enabled by macro PLL_LOCK_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.master bus
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic            loss_evt;
  logic            pll_rst_q, sys_reset_n_q, lock_ok_q, fail_q;

  assign locked_s  = sync_q[1];
  assign retry_inc = (retry_q == RW'(MAX_RETRIES)) ? retry_q : retry_q + RW'(1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked};
    end
  end

  // relock_req is tested first in every state so it beats lock loss, timeout and completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    loss_evt = 1'b0;
    case (state_q)
      S_RESET_PLL: begin
        if (bus.relock_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end else if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RW'(MAX_RETRIES)) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end else if (!locked_s) begin
          state_d  = S_RESET_PLL;
          loss_evt = 1'b1;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        retry_d = '0;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_ok_q     <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_reset_n_q <= (state_d == S_RUN);
      lock_ok_q     <= (state_d == S_RUN);
      fail_q        <= (state_d == S_FAIL);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.lock_ok     = lock_ok_q;
  assign bus.fail        = fail_q;
  assign bus.state       = state_q;
  assign bus.retry_cnt   = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_q;
`else
  logic unused_loss;
  assign unused_loss = loss_evt;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the fabric PLL (50 MHz refclk in, 80 MHz outclk_0 out) from power-up to a trusted locked state.
- Drives the PLL reset and watches its locked output.
- Generates the downstream system reset that gates the AES datapath clock domain.
- Handles lock loss, retries, software relock requests and a terminal fail state.
- Runs on the free-running reference clock, never on the PLL output.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the attempt is abandoned.
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 3: failed lock attempts before entering FAIL (>=1).
- CNT_W, 17: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk  in  1  reference clock, 50 MHz, free-running.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- relock_req  in  1  single-cycle request to restart the PLL sequence.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset_n  out  1  active-low downstream reset; asserts asynchronously, deasserts synchronously.
- lock_ok  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- state  out  3  encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts since the last RUN or relock.

Behaviour:
- Reset (rst_n=0, async):
  - state=RESET_PLL, counter=0, retry_cnt=0.
  - pll_rst=1, sys_reset_n=0, lock_ok=0, fail=0.
  - Synchronizer flops cleared.
- pll_locked passes through a 2-FF synchronizer giving locked_s; it contributes 2 cycles of latency to every lock decision.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- Single counter, cleared on every state transition.
- RESET_PLL:
  - pll_rst=1, sys_reset_n=0.
  - Counter increments; at counter==RST_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0, sys_reset_n=0.
  - locked_s=1 -> STABLE.
  - Otherwise, at counter==LOCK_TIMEOUT-1, retry_cnt+1. If the new value equals MAX_RETRIES -> FAIL, else -> RESET_PLL.
  - Lock seen on the timeout cycle wins; it goes to STABLE with no retry counted.
- STABLE:
  - pll_rst=0, sys_reset_n=0.
  - locked_s=0 -> WAIT_LOCK; counter restarts and no retry is counted.
  - STABLE_CYCLES consecutive cycles of locked_s=1 -> RUN.
- RUN:
  - pll_rst=0, sys_reset_n=1, lock_ok=1, retry_cnt cleared to 0.
  - locked_s=0 -> RESET_PLL; sys_reset_n drops on that same edge and retry_cnt stays 0.
- FAIL:
  - pll_rst=1, sys_reset_n=0, fail=1.
  - Held indefinitely; exits only on relock_req or rst_n.
- relock_req:
  - In any state other than RESET_PLL -> RESET_PLL, retry_cnt=0.
  - In RESET_PLL it restarts the counter.
  - Priority over lock loss, timeout and stable completion when they fall on the same cycle.
- retry_cnt saturates at MAX_RETRIES.
- Counter never wraps; every state exits on or before its terminal count.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- When defined:
  - Adds output lock_loss_cnt (out, 8).
  - Increments on each RUN->RESET_PLL transition caused by locked_s=0; relock_req-initiated exits are not counted.
  - Saturates at 255.
  - Cleared only by rst_n.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, pll_locked rises 10 cycles after pll_rst falls and stays high:
  - pll_rst high exactly 4 cycles.
  - sys_reset_n rises 10+2+8 cycles after pll_rst falls (±1 for async sampling).
  - state ends at 3, lock_ok=1.
- pll_locked never asserts:
  - Two 32-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_rst pulse.
  - Then state=4, fail=1, pll_rst=1, retry_cnt=2.
- In FAIL, pulse relock_req with pll_locked=1:
  - retry_cnt=0, pll_rst pulse of 4 cycles, then RUN reached.
- In RUN, drop pll_locked for 1 cycle:
  - sys_reset_n=0 within 3 cycles, new 4-cycle pll_rst pulse.
  - With the macro defined, lock_loss_cnt goes 0->1.
- In STABLE, glitch pll_locked low after 5 stable cycles:
  - Return to WAIT_LOCK, no retry counted.
  - RUN requires a fresh 8-cycle window.
- Assert rst_n=0 mid-RUN:
  - sys_reset_n=0 and pll_rst=1 immediately (same time step, no clock edge).
  - Full sequence repeats after release.
